serial_uart_bridge: RTL and testbench
=====================================

# serial_uart_bridge

Serial device endpoint for the memory-mapped serial buffer at 0xFFFF0000. It accepts bytes the core writes, serialises them onto a UART TX line, and deserialises the UART RX line into bytes the core reads. Both directions are buffered by FIFOs. It sits at the top level between the data memory's serial port and the board UART pins, using 8N1 framing, LSB first.

## Interface
- CLKS_PER_BIT, 434: clock cycles per UART bit, ≥4 (434 = 50 MHz / 115200).
- FIFO_AW, 4: FIFO address width; each FIFO holds 2^FIFO_AW entries.
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low (reset = 0 clears all state immediately).
- wr_data_in  in  8  byte from core (data memory serial_out).
- wren_in  in  1  push wr_data_in into TX FIFO (data memory serial_wren_out).
- ready_out  out  1  TX FIFO not full (to data memory serial_ready_in).
- rd_data_out  out  8  RX FIFO head byte (to data memory serial_in).
- valid_out  out  1  RX FIFO not empty (to data memory serial_valid_in).
- rden_in  in  1  pop RX FIFO head (data memory serial_rden_out).
- uart_rx_in  in  1  asynchronous UART receive line.
- uart_tx_out  out  1  UART transmit line, registered.
- clr_status_in  in  1  clears sticky flags.
- overrun_out  out  1  sticky: received byte dropped because RX FIFO full.
- frame_err_out  out  1  sticky: stop bit sampled low.

## Operation
- Reset values:
  - uart_tx_out = 1, ready_out = 1, valid_out = 0, rd_data_out = 0, overrun_out = 0, frame_err_out = 0.
  - Both FIFOs are empty and both FSMs are in IDLE.
- FIFOs:
  - Synchronous, show-ahead, with separate read/write pointers and a count of width FIFO_AW+1; pointers wrap modulo 2^FIFO_AW.
  - ready_out and valid_out derive from the registered count only.
- Core write:
  - wren_in && ready_out pushes the byte.
  - wren_in while full is silently dropped; FIFO contents are unchanged.
- Core read:
  - rd_data_out shows the head byte whenever valid_out = 1.
  - rden_in && valid_out pops the head.
  - rden_in while empty is ignored.
- TX FSM (IDLE, START, DATA, STOP), with a bit counter of 3 bits and a baud counter of 0..CLKS_PER_BIT-1:
  - IDLE: if the TX FIFO is non-empty, pop it into the shift register and go to START.
  - START drives 0; DATA drives shift[0] and shifts right each bit for 8 bits; STOP drives 1.
  - Each state lasts CLKS_PER_BIT cycles. After STOP, return to IDLE; back-to-back frames are allowed with no idle gap.
- RX FSM (IDLE, START, DATA, STOP):
  - uart_rx_in passes through a 2-flop synchroniser first.
  - IDLE: on synchronised 0, go to START.
  - START: wait CLKS_PER_BIT/2 cycles, then resample. If 1 (false start), return to IDLE. If 0, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles (mid-bit), LSB first, for 8 bits.
  - STOP: sample after CLKS_PER_BIT cycles.
    - If 1: push the byte. If the FIFO is full and there is no same-cycle pop, drop it and set overrun_out.
    - If 0: discard the byte and set frame_err_out.
    - In both cases return to IDLE.
- Sticky flags:
  - clr_status_in clears both flags.
  - A set event in the same cycle as a clear wins: the flag is 1.

## Timing
- TX latency:
  - Byte written at edge N (FIFO previously empty, TX IDLE): FIFO count is 1 after N, the FSM pops at edge N+1, and uart_tx_out = 0 after edge N+2.
  - Frame length is exactly 10×CLKS_PER_BIT cycles.
- RX latency: valid_out rises in the cycle after the STOP mid-bit sample edge.
- Full boundary:
  - Simultaneous push and pop on a full RX FIFO: both occur, and the count stays full.
  - ready_out reflects the pre-edge count, so a TX FIFO pop and a core write in the same cycle while full still drops the write.
- Empty boundary: simultaneous push and pop on an empty FIFO means the pop is ignored and the push succeeds.
- Reset asserted mid-frame: uart_tx_out returns to 1 immediately and the partial RX byte is discarded. After release, the RX FSM restarts in IDLE and needs a fresh falling edge.

## Test plan
Use CLKS_PER_BIT = 4 and FIFO_AW = 2 throughout.
- Write 0xA5 -> uart_tx_out falls 2 cycles later, then shows bits 1,0,1,0,0,1,0,1, then stop bit 1, each for 4 cycles; total frame 40 cycles.
- Drive a UART frame of 0x3C on uart_rx_in -> valid_out = 1, rd_data_out = 0x3C; pulse rden_in -> valid_out = 0 next cycle.
- Receive 5 bytes (0x01..0x05) with no reads -> FIFO holds 0x01..0x04, overrun_out = 1; reads return 0x01..0x04 in order; clr_status_in -> overrun_out = 0.
- Write 6 bytes back-to-back -> ready_out falls after the FIFO fills; the byte not accepted is never transmitted; accepted bytes go out contiguously with no idle gaps.
- RX frame with stop bit 0 -> no push, frame_err_out = 1. A 1-cycle low glitch -> false start, no push, no flag.
- Assert reset mid-TX frame -> uart_tx_out = 1 and ready_out = 1 immediately; FIFOs are empty and all flags are 0 after release.

Source files
------------

// File: rtl/serial_uart_bridge.sv
// serial_uart_bridge: memory-mapped serial endpoint. Core writes are buffered
// in a TX FIFO and sent as 8N1 UART frames (LSB first). UART frames received
// on uart_rx_in are buffered in an RX FIFO for the core to read. The sticky
// overrun and frame-error flags are cleared by clr_status_in.

// Byte FIFO: synchronous, show-ahead, 2^AW entries, with an occupancy count.
module serial_uart_bridge_fifo #(
    parameter int AW = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push_in,
    input  logic [7:0] data_in,
    input  logic       pop_in,
    output logic [7:0] head_out,
    output logic       full_out,
    output logic       empty_out
);
    localparam int DEPTH = 1 << AW;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    // The count only reaches 2^AW when full, so its top bit is the full flag.
    assign full_out  = count_q[AW];
    assign empty_out = (count_q == '0);
    assign head_out  = mem_q[rd_ptr_q];

    // Pointer and count update; a push into a full FIFO needs a same-cycle pop.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop_in && !empty_out;
        do_push  = push_in && (!full_out || do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    // Pointer and count registers.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array.
    always_ff @(posedge clock) begin
        // NOTE: the array is not reset; the count marks every entry invalid, and
        // leaving it reset-free lets it map onto RAM.
        if (do_push) mem_q[wr_ptr_q] <= data_in;
    end
endmodule

module serial_uart_bridge #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] wr_data_in,
    input  logic       wren_in,
    output logic       ready_out,
    output logic [7:0] rd_data_out,
    output logic       valid_out,
    input  logic       rden_in,
    input  logic       uart_rx_in,
    output logic       uart_tx_out,
    input  logic       clr_status_in,
    output logic       overrun_out,
    output logic       frame_err_out
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;

    // FIFO hookup
    logic       tx_full, tx_empty, tx_pop;
    logic [7:0] tx_head;
    logic       rx_full, rx_empty, rx_push;
    logic [7:0] rx_head;

    // TX state
    uart_state_e       tx_state_q, tx_state_d;
    logic [BAUD_W-1:0] tx_baud_q, tx_baud_d;
    logic [2:0]        tx_bit_q, tx_bit_d;
    logic [7:0]        tx_shift_q, tx_shift_d;
    logic              tx_out_q, tx_out_d;

    // RX state
    logic [1:0]        rx_sync_q, rx_sync_d;
    uart_state_e       rx_state_q, rx_state_d;
    logic [BAUD_W-1:0] rx_baud_q, rx_baud_d;
    logic [2:0]        rx_bit_q, rx_bit_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic              rx_ferr_set;
    logic              rx_bit_s;

    // Sticky flags
    logic overrun_q, overrun_d;
    logic frame_err_q, frame_err_d;

    serial_uart_bridge_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push_in   (wren_in && ready_out),
        .data_in   (wr_data_in),
        .pop_in    (tx_pop),
        .head_out  (tx_head),
        .full_out  (tx_full),
        .empty_out (tx_empty)
    );

    serial_uart_bridge_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push_in   (rx_push),
        .data_in   (rx_shift_q),
        .pop_in    (rden_in),
        .head_out  (rx_head),
        .full_out  (rx_full),
        .empty_out (rx_empty)
    );

    assign ready_out     = !tx_full;
    assign valid_out     = !rx_empty;
    assign rd_data_out   = valid_out ? rx_head : 8'h00;
    assign uart_tx_out   = tx_out_q;
    assign overrun_out   = overrun_q;
    assign frame_err_out = frame_err_q;
    assign rx_bit_s      = rx_sync_q[1];

    // TX next state: pop a byte, then start bit, 8 data bits, stop bit; the
    // next byte is popped at the end of STOP so frames can run back-to-back.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_baud_d  = tx_baud_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        unique case (tx_state_q)
            ST_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_baud_d  = '0;
                    tx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (tx_baud_q == BAUD_LAST) begin
                    tx_baud_d  = '0;
                    tx_bit_d   = '0;
                    tx_state_d = ST_DATA;
                end else begin
                    tx_baud_d = tx_baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (tx_baud_q == BAUD_LAST) begin
                    tx_baud_d  = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 1'b1;
                    if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
                end else begin
                    tx_baud_d = tx_baud_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (tx_baud_q == BAUD_LAST) begin
                    tx_baud_d = '0;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        tx_state_d = ST_START;
                    end else begin
                        tx_state_d = ST_IDLE;
                    end
                end else begin
                    tx_baud_d = tx_baud_q + 1'b1;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    // TX line level for the current state, registered so the pin is glitch-free.
    always_comb begin
        tx_out_d = 1'b1;
        unique case (tx_state_q)
            ST_START: tx_out_d = 1'b0;
            ST_DATA:  tx_out_d = tx_shift_q[0];
            default:  tx_out_d = 1'b1;
        endcase
    end

    // TX registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state_q <= ST_IDLE;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_out_q   <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_out_q   <= tx_out_d;
        end
    end

    // RX next state: synchronise the line, confirm the start bit at half a bit,
    // then sample each data bit and the stop bit in the middle of the bit.
    always_comb begin
        rx_sync_d   = {rx_sync_q[0], uart_rx_in};
        rx_state_d  = rx_state_q;
        rx_baud_d   = rx_baud_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_push     = 1'b0;
        rx_ferr_set = 1'b0;
        unique case (rx_state_q)
            ST_IDLE: begin
                if (!rx_bit_s) begin
                    rx_baud_d  = '0;
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (rx_baud_q == BAUD_HALF) begin
                    rx_baud_d = '0;
                    rx_bit_d  = '0;
                    // A line already back high was noise, not a start bit.
                    rx_state_d = rx_bit_s ? ST_IDLE : ST_DATA;
                end else begin
                    rx_baud_d = rx_baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (rx_baud_q == BAUD_LAST) begin
                    rx_baud_d  = '0;
                    rx_shift_d = {rx_bit_s, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
                end else begin
                    rx_baud_d = rx_baud_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (rx_baud_q == BAUD_LAST) begin
                    rx_baud_d   = '0;
                    rx_state_d  = ST_IDLE;
                    rx_push     = rx_bit_s;
                    rx_ferr_set = !rx_bit_s;
                end else begin
                    rx_baud_d = rx_baud_q + 1'b1;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    // RX registers; the synchroniser idles high like the line.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_sync_q  <= 2'b11;
            rx_state_q <= ST_IDLE;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_sync_q  <= rx_sync_d;
            rx_state_q <= rx_state_d;
            rx_baud_q  <= rx_baud_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // Sticky flags: a set event outranks a clear in the same cycle.
    always_comb begin
        overrun_d   = (rx_push && rx_full && !rden_in) || (overrun_q && !clr_status_in);
        frame_err_d = rx_ferr_set || (frame_err_q && !clr_status_in);
    end

    // Flag registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end
endmodule

// File: tb/tb_serial_uart_bridge.sv
// Directed testbench for serial_uart_bridge with 4 clocks per bit and
// 4-entry FIFOs. Inputs change and outputs are sampled on the falling edge.
module tb_serial_uart_bridge;
    localparam int CPB = 4;
    localparam int AW  = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] wr_data_in;
    logic       wren_in;
    logic       ready_out;
    logic [7:0] rd_data_out;
    logic       valid_out;
    logic       rden_in;
    logic       uart_rx_in;
    logic       uart_tx_out;
    logic       clr_status_in;
    logic       overrun_out;
    logic       frame_err_out;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clock = ~clock;

    serial_uart_bridge #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .clock         (clock),
        .reset         (reset),
        .wr_data_in    (wr_data_in),
        .wren_in       (wren_in),
        .ready_out     (ready_out),
        .rd_data_out   (rd_data_out),
        .valid_out     (valid_out),
        .rden_in       (rden_in),
        .uart_rx_in    (uart_rx_in),
        .uart_tx_out   (uart_tx_out),
        .clr_status_in (clr_status_in),
        .overrun_out   (overrun_out),
        .frame_err_out (frame_err_out)
    );

    // Line level at cycle p of a 10-bit 8N1 frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int p);
        if (p < CPB) return 1'b0;
        if (p < 9 * CPB) return b[(p - CPB) / CPB];
        return 1'b1;
    endfunction

    // Drive one UART frame onto uart_rx_in; called and returns on a falling edge.
    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        for (int p = 0; p < 10 * CPB; p++) begin
            uart_rx_in = (p >= 9 * CPB) ? stop_bit : frame_bit(b, p);
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        total_cnt++; if (uart_tx_out !== 1'b1) $display("FAIL reset_tx: got %b want 1", uart_tx_out); else pass_cnt++;
        total_cnt++; if (ready_out !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready_out); else pass_cnt++;
        total_cnt++; if (valid_out !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_out); else pass_cnt++;
        total_cnt++; if (rd_data_out !== 8'h00) $display("FAIL reset_rd_data: got %h want 00", rd_data_out); else pass_cnt++;
        total_cnt++; if (overrun_out !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun_out); else pass_cnt++;
        total_cnt++; if (frame_err_out !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err_out); else pass_cnt++;
        reset = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    // Write 0xA5: line stays high for the edges N and N+1, falls after N+2,
    // then holds each of the 10 frame bits for CPB cycles.
    task automatic test_tx_frame();
        logic [7:0] b;
        b = 8'hA5;
        wr_data_in = b;
        wren_in    = 1'b1;
        @(negedge clock);
        wren_in = 1'b0;
        total_cnt++; if (uart_tx_out !== 1'b1) $display("FAIL tx_latency_n: got %b want 1", uart_tx_out); else pass_cnt++;
        @(negedge clock);
        total_cnt++; if (uart_tx_out !== 1'b1) $display("FAIL tx_latency_n1: got %b want 1", uart_tx_out); else pass_cnt++;
        for (int k = 0; k < 10 * CPB; k++) begin
            @(negedge clock);
            total_cnt++;
            if (uart_tx_out !== frame_bit(b, k))
                $display("FAIL tx_frame_a5 cycle %0d: got %b want %b", k, uart_tx_out, frame_bit(b, k));
            else pass_cnt++;
        end
        @(negedge clock);
        total_cnt++; if (uart_tx_out !== 1'b1) $display("FAIL tx_after_frame: got %b want 1", uart_tx_out); else pass_cnt++;
        total_cnt++; if (ready_out !== 1'b1) $display("FAIL tx_ready_after: got %b want 1", ready_out); else pass_cnt++;
    endtask

    task automatic test_rx_basic();
        send_rx(8'h3C, 1'b1);
        uart_rx_in = 1'b1;
        // Stop bit is sampled mid-bit at the next edge; valid only after it.
        total_cnt++; if (valid_out !== 1'b0) $display("FAIL rx_valid_early: got %b want 0", valid_out); else pass_cnt++;
        @(negedge clock);
        total_cnt++; if (valid_out !== 1'b1) $display("FAIL rx_valid: got %b want 1", valid_out); else pass_cnt++;
        total_cnt++; if (rd_data_out !== 8'h3C) $display("FAIL rx_data: got %h want 3c", rd_data_out); else pass_cnt++;
        total_cnt++; if (frame_err_out !== 1'b0) $display("FAIL rx_no_ferr: got %b want 0", frame_err_out); else pass_cnt++;
        rden_in = 1'b1;
        @(negedge clock);
        rden_in = 1'b0;
        total_cnt++; if (valid_out !== 1'b0) $display("FAIL rx_pop_valid: got %b want 0", valid_out); else pass_cnt++;
        total_cnt++; if (rd_data_out !== 8'h00) $display("FAIL rx_pop_data: got %h want 00", rd_data_out); else pass_cnt++;
        repeat (4) @(negedge clock);
    endtask

    task automatic test_rx_overrun();
        logic [7:0] exp;
        for (int i = 1; i <= 5; i++) begin
            send_rx(8'(i), 1'b1);
            uart_rx_in = 1'b1;
            repeat (4) @(negedge clock);
        end
        total_cnt++; if (overrun_out !== 1'b1) $display("FAIL ovr_flag: got %b want 1", overrun_out); else pass_cnt++;
        total_cnt++; if (valid_out !== 1'b1) $display("FAIL ovr_valid: got %b want 1", valid_out); else pass_cnt++;
        for (int i = 1; i <= 4; i++) begin
            exp = 8'(i);
            total_cnt++;
            if (rd_data_out !== exp) $display("FAIL ovr_read_%0d: got %h want %h", i, rd_data_out, exp);
            else pass_cnt++;
            rden_in = 1'b1;
            @(negedge clock);
            rden_in = 1'b0;
        end
        total_cnt++; if (valid_out !== 1'b0) $display("FAIL ovr_drained: got %b want 0", valid_out); else pass_cnt++;
        total_cnt++; if (overrun_out !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", overrun_out); else pass_cnt++;
        clr_status_in = 1'b1;
        @(negedge clock);
        clr_status_in = 1'b0;
        total_cnt++; if (overrun_out !== 1'b0) $display("FAIL ovr_clear: got %b want 0", overrun_out); else pass_cnt++;
    endtask

    // Six writes on consecutive edges: the first is popped at once, the next
    // four fill the FIFO, the sixth is dropped. Five frames follow with no gap.
    task automatic test_back_to_back();
        logic [7:0] bytes [6];
        logic [5:0] ready_exp;
        logic       exp;
        bytes = '{8'h81, 8'h42, 8'hFF, 8'h00, 8'h3C, 8'h99};
        ready_exp = 6'b001111;  // bit c: ready after edge N+c
        wr_data_in = bytes[0];
        wren_in    = 1'b1;
        for (int c = 0; c < 2 + 50 * CPB + 3 * CPB; c++) begin
            @(negedge clock);
            if (c < 5) wr_data_in = bytes[c + 1];
            else wren_in = 1'b0;
            if (c < 6) begin
                total_cnt++;
                if (ready_out !== ready_exp[c]) $display("FAIL b2b_ready edge %0d: got %b want %b", c, ready_out, ready_exp[c]);
                else pass_cnt++;
            end
            if (c >= 2) begin
                exp = (c - 2 < 50 * CPB) ? frame_bit(bytes[(c - 2) / (10 * CPB)], (c - 2) % (10 * CPB)) : 1'b1;
                total_cnt++;
                if (uart_tx_out !== exp) $display("FAIL b2b_tx cycle %0d: got %b want %b", c - 2, uart_tx_out, exp);
                else pass_cnt++;
            end
        end
        total_cnt++; if (ready_out !== 1'b1) $display("FAIL b2b_ready_end: got %b want 1", ready_out); else pass_cnt++;
    endtask

    task automatic test_rx_errors();
        logic seen;
        // Clear held across the bad stop bit: the set must still show for a cycle.
        clr_status_in = 1'b1;
        send_rx(8'h55, 1'b0);
        uart_rx_in = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (frame_err_out === 1'b1) seen = 1'b1;
        end
        clr_status_in = 1'b0;
        total_cnt++; if (seen !== 1'b1) $display("FAIL ferr_set_beats_clear: got %b want 1", seen); else pass_cnt++;
        total_cnt++; if (frame_err_out !== 1'b0) $display("FAIL ferr_cleared: got %b want 0", frame_err_out); else pass_cnt++;
        repeat (10) @(negedge clock);
        // Plain bad frame: no push, sticky error.
        send_rx(8'h55, 1'b0);
        uart_rx_in = 1'b1;
        repeat (10) @(negedge clock);
        total_cnt++; if (frame_err_out !== 1'b1) $display("FAIL ferr_flag: got %b want 1", frame_err_out); else pass_cnt++;
        total_cnt++; if (valid_out !== 1'b0) $display("FAIL ferr_no_push: got %b want 0", valid_out); else pass_cnt++;
        clr_status_in = 1'b1;
        @(negedge clock);
        clr_status_in = 1'b0;
        total_cnt++; if (frame_err_out !== 1'b0) $display("FAIL ferr_clear: got %b want 0", frame_err_out); else pass_cnt++;
        // One-cycle low glitch is a false start.
        uart_rx_in = 1'b0;
        @(negedge clock);
        uart_rx_in = 1'b1;
        repeat (20) @(negedge clock);
        total_cnt++; if (valid_out !== 1'b0) $display("FAIL glitch_no_push: got %b want 0", valid_out); else pass_cnt++;
        total_cnt++; if (frame_err_out !== 1'b0) $display("FAIL glitch_no_ferr: got %b want 0", frame_err_out); else pass_cnt++;
        total_cnt++; if (overrun_out !== 1'b0) $display("FAIL glitch_no_ovr: got %b want 0", overrun_out); else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        int tx_bad;
        logic [7:0] wbytes [3];
        wbytes = '{8'h00, 8'hFF, 8'h0F};
        uart_rx_in = 1'b0;  // partial RX frame in flight when reset hits
        wren_in    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data_in = wbytes[i];
            @(negedge clock);
        end
        wren_in = 1'b0;
        repeat (16) @(negedge clock);
        total_cnt++; if (uart_tx_out !== 1'b0) $display("FAIL rst_mid_frame_pre: got %b want 0", uart_tx_out); else pass_cnt++;
        #2;
        reset      = 1'b0;
        uart_rx_in = 1'b1;
        #1;
        total_cnt++; if (uart_tx_out !== 1'b1) $display("FAIL rst_async_tx: got %b want 1", uart_tx_out); else pass_cnt++;
        total_cnt++; if (ready_out !== 1'b1) $display("FAIL rst_async_ready: got %b want 1", ready_out); else pass_cnt++;
        total_cnt++; if (valid_out !== 1'b0) $display("FAIL rst_async_valid: got %b want 0", valid_out); else pass_cnt++;
        @(negedge clock);
        reset = 1'b1;
        tx_bad = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            if (uart_tx_out !== 1'b1) tx_bad++;
        end
        total_cnt++; if (tx_bad != 0) $display("FAIL rst_tx_fifo_empty: got %0d low cycles want 0", tx_bad); else pass_cnt++;
        total_cnt++; if (valid_out !== 1'b0) $display("FAIL rst_rx_discard: got %b want 0", valid_out); else pass_cnt++;
        total_cnt++; if (overrun_out !== 1'b0) $display("FAIL rst_ovr: got %b want 0", overrun_out); else pass_cnt++;
        total_cnt++; if (frame_err_out !== 1'b0) $display("FAIL rst_ferr: got %b want 0", frame_err_out); else pass_cnt++;
        send_rx(8'h5A, 1'b1);
        uart_rx_in = 1'b1;
        repeat (4) @(negedge clock);
        total_cnt++; if (valid_out !== 1'b1) $display("FAIL rst_rx_again_valid: got %b want 1", valid_out); else pass_cnt++;
        total_cnt++; if (rd_data_out !== 8'h5A) $display("FAIL rst_rx_again_data: got %h want 5a", rd_data_out); else pass_cnt++;
    endtask

    initial begin
        reset         = 1'b0;
        wr_data_in    = 8'h00;
        wren_in       = 1'b0;
        rden_in       = 1'b0;
        uart_rx_in    = 1'b1;
        clr_status_in = 1'b0;
        test_reset();
        test_tx_frame();
        test_rx_basic();
        test_rx_overrun();
        test_back_to_back();
        test_rx_errors();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
